// File: rtl/npu_wb_loader.sv
// npu_wb_loader
// Wishbone initiator that copies a block of 32-bit words from a source region
// to a destination region on the same bus, one word at a time (read, then write).
// An idle bus cycle follows every acknowledged transfer. This lets slaves with
// a registered, non-self-clearing ack be used safely.
//
// Optional build macro: NPU_WB_TIMEOUT_EN
//   Enables an ack timeout. A transfer is aborted after TIMEOUT_CYCLES
//   stb-high cycles without ack, and err_o pulses together with done_o.
//   When the macro is undefined, the block waits for ack indefinitely and
//   err_o is tied to 0.
//
// Ports:
//   wb_clk_i, wb_rst_ni       clock, asynchronous active-low reset
//   start_i                   single-cycle command strobe (sampled in IDLE only)
//   src_adr_i, dst_adr_i      source / destination byte addresses
//   len_i                     word count (0 completes without bus activity)
//   dst_inc_i                 1 = incrementing destination, 0 = fixed (stream port)
//   busy_o, done_o, err_o     command status; done_o/err_o are one-cycle pulses
//   words_o                   words written in the current or last command
//   wbm_*                     Wishbone master port
module npu_wb_loader #(
  parameter int LEN_W          = 8,
  parameter int ADR_STEP       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             dst_inc_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_GAP, S_WR, S_WR_GAP, S_DONE
  } state_t;

  state_t           r_state, w_state;
  logic [31:0]      r_src, w_src;
  logic [31:0]      r_dst, w_dst;
  logic [LEN_W-1:0] r_len, w_len;
  logic             r_inc, w_inc;
  logic [31:0]      r_buf, w_buf;
  logic [LEN_W-1:0] r_words, w_words;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_cyc, w_cyc;
  logic             r_stb, w_stb;
  logic             r_we, w_we;
  logic [3:0]       r_sel, w_sel;
  logic [31:0]      r_adr, w_adr;
  logic [31:0]      r_dat, w_dat;

`ifdef NPU_WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo, w_tmo;
  logic             r_abort, w_abort;
  logic             r_err, w_err;
  logic             w_tmo_hit;
  // Last stb-high cycle allowed without ack.
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err_o     = r_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_inc   <= 1'b0;
      r_buf   <= '0;
      r_words <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
`ifdef NPU_WB_TIMEOUT_EN
      r_tmo   <= '0;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_src   <= w_src;
      r_dst   <= w_dst;
      r_len   <= w_len;
      r_inc   <= w_inc;
      r_buf   <= w_buf;
      r_words <= w_words;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_cyc   <= w_cyc;
      r_stb   <= w_stb;
      r_we    <= w_we;
      r_sel   <= w_sel;
      r_adr   <= w_adr;
      r_dat   <= w_dat;
`ifdef NPU_WB_TIMEOUT_EN
      r_tmo   <= w_tmo;
      r_abort <= w_abort;
      r_err   <= w_err;
`endif
    end
  end

  // Bus outputs are registered and loaded on the transition into a bus state,
  // so they are glitch-free and the address/data hold their last value.
  always_comb begin
    w_state = r_state;
    w_src   = r_src;
    w_dst   = r_dst;
    w_len   = r_len;
    w_inc   = r_inc;
    w_buf   = r_buf;
    w_words = r_words;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_cyc   = r_cyc;
    w_stb   = r_stb;
    w_we    = r_we;
    w_sel   = r_sel;
    w_adr   = r_adr;
    w_dat   = r_dat;
`ifdef NPU_WB_TIMEOUT_EN
    w_tmo   = r_tmo;
    w_abort = r_abort;
    w_err   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_src   = src_adr_i;
          w_dst   = dst_adr_i;
          w_len   = len_i;
          w_inc   = dst_inc_i;
          w_words = '0;
          w_busy  = 1'b1;
`ifdef NPU_WB_TIMEOUT_EN
          w_abort = 1'b0;
          w_tmo   = '0;
`endif
          if (len_i == '0) begin
            w_state = S_DONE;
          end else begin
            w_state = S_RD;
            w_cyc   = 1'b1;
            w_stb   = 1'b1;
            w_we    = 1'b0;
            w_sel   = 4'hF;
            w_adr   = src_adr_i;
          end
        end
      end
      S_RD: begin
        if (wbm_ack_i) begin
          w_buf   = wbm_dat_i;
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
          w_state = S_RD_GAP;
        end
`ifdef NPU_WB_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
          w_abort = 1'b1;
          w_state = S_DONE;
        end else begin
          w_tmo = r_tmo + TMO_W'(1);
        end
`endif
      end
      S_RD_GAP: begin
        w_src   = r_src + 32'(ADR_STEP);
        w_state = S_WR;
        w_cyc   = 1'b1;
        w_stb   = 1'b1;
        w_we    = 1'b1;
        w_sel   = 4'hF;
        w_adr   = r_dst;
        w_dat   = r_buf;
`ifdef NPU_WB_TIMEOUT_EN
        w_tmo   = '0;
`endif
      end
      S_WR: begin
        if (wbm_ack_i) begin
          w_words = r_words + LEN_W'(1);
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
          w_we    = 1'b0;
          w_state = S_WR_GAP;
        end
`ifdef NPU_WB_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
          w_we    = 1'b0;
          w_abort = 1'b1;
          w_state = S_DONE;
        end else begin
          w_tmo = r_tmo + TMO_W'(1);
        end
`endif
      end
      S_WR_GAP: begin
        if (r_inc) begin
          w_dst = r_dst + 32'(ADR_STEP);
        end
        if (r_words == r_len) begin
          w_state = S_DONE;
        end else begin
          w_state = S_RD;
          w_cyc   = 1'b1;
          w_stb   = 1'b1;
          w_we    = 1'b0;
          w_sel   = 4'hF;
          // Source address was already advanced in RD_GAP.
          w_adr   = r_src;
`ifdef NPU_WB_TIMEOUT_EN
          w_tmo   = '0;
`endif
        end
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_state = S_IDLE;
`ifdef NPU_WB_TIMEOUT_EN
        w_err   = r_abort;
`endif
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign words_o   = r_words;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;

endmodule
